// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry saturating direction counters; combinational lookup, ID-stage training.
// Optional perf counters are enabled by defining BP_PERF_EN.
module branch_predictor_btb #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_pc_i,
  output logic              pred_hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_en_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_mispred_i,
`ifdef BP_PERF_EN
  output logic [31:0]       perf_lookup_o,
  output logic [31:0]       perf_update_o,
  output logic [31:0]       perf_mispred_o,
`endif
  input  logic              flush_i
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_LO = IDX_W + 2;
  localparam int unsigned TAG_HI = IDX_W + 2 + TAG_W - 1;
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [ADDR_W-1:0]  target_d [ENTRIES];
  logic [CNT_W-1:0]   cnt_q    [ENTRIES];
  logic [CNT_W-1:0]   cnt_d    [ENTRIES];

  logic [IDX_W-1:0] lk_idx_c, up_idx_c;
  logic [TAG_W-1:0] lk_tag_c, up_tag_c;
  logic             up_hit_c;

  assign lk_idx_c = lookup_pc_i[IDX_W+1:2];
  assign lk_tag_c = lookup_pc_i[TAG_HI:TAG_LO];
  assign up_idx_c = upd_pc_i[IDX_W+1:2];
  assign up_tag_c = upd_pc_i[TAG_HI:TAG_LO];
  assign up_hit_c = valid_q[up_idx_c] && (tag_q[up_idx_c] == up_tag_c);

  // Lookup reads only registered state, so a same-cycle update is not bypassed.
  assign pred_hit_o    = valid_q[lk_idx_c] && (tag_q[lk_idx_c] == lk_tag_c);
  assign pred_taken_o  = pred_hit_o && cnt_q[lk_idx_c][CNT_W-1];
  assign pred_target_o = pred_taken_o ? target_q[lk_idx_c] : lookup_pc_i + ADDR_W'(4);

  // Table next state: flush wins over update; not-taken misses never allocate.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      valid_d = '0;
      for (int i = 0; i < int'(ENTRIES); i++) cnt_d[i] = CNT_RST;
    end else if (upd_en_i) begin
      if (up_hit_c) begin
        if (upd_taken_i) begin
          if (cnt_q[up_idx_c] != CNT_MAX) cnt_d[up_idx_c] = cnt_q[up_idx_c] + CNT_W'(1);
          target_d[up_idx_c] = upd_target_i;
        end else if (cnt_q[up_idx_c] != '0) begin
          cnt_d[up_idx_c] = cnt_q[up_idx_c] - CNT_W'(1);
        end
      end else if (upd_taken_i) begin
        valid_d[up_idx_c]  = 1'b1;
        tag_d[up_idx_c]    = up_tag_c;
        target_d[up_idx_c] = upd_target_i;
        cnt_d[up_idx_c]    = CNT_WT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_RST;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

`ifdef BP_PERF_EN
  logic [31:0] perf_lookup_q, perf_lookup_d;
  logic [31:0] perf_update_q, perf_update_d;
  logic [31:0] perf_mispred_q, perf_mispred_d;

  // Saturating event counters; flush leaves them alone.
  always_comb begin
    perf_lookup_d  = perf_lookup_q;
    perf_update_d  = perf_update_q;
    perf_mispred_d = perf_mispred_q;
    if (perf_lookup_q != 32'hFFFF_FFFF) perf_lookup_d = perf_lookup_q + 32'd1;
    if (upd_en_i && perf_update_q != 32'hFFFF_FFFF) perf_update_d = perf_update_q + 32'd1;
    if (upd_en_i && upd_mispred_i && perf_mispred_q != 32'hFFFF_FFFF)
      perf_mispred_d = perf_mispred_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_lookup_q  <= '0;
      perf_update_q  <= '0;
      perf_mispred_q <= '0;
    end else begin
      perf_lookup_q  <= perf_lookup_d;
      perf_update_q  <= perf_update_d;
      perf_mispred_q <= perf_mispred_d;
    end
  end

  assign perf_lookup_o  = perf_lookup_q;
  assign perf_update_o  = perf_update_q;
  assign perf_mispred_o = perf_mispred_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i[1:0], lookup_pc_i[ADDR_W-1:TAG_HI+1],
                            upd_pc_i[1:0], upd_pc_i[ADDR_W-1:TAG_HI+1]};
`else
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i[1:0], lookup_pc_i[ADDR_W-1:TAG_HI+1],
                            upd_pc_i[1:0], upd_pc_i[ADDR_W-1:TAG_HI+1], upd_mispred_i};
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench for branch_predictor_btb: a driver pushes model predictions, a monitor compares DUT lookups.
module tb_branch_predictor_btb;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned TAG_W   = 8;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned IDX_W   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] lookup_pc_i = '0;
  logic        pred_hit_o, pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_en_i = 1'b0;
  logic [31:0] upd_pc_i = '0;
  logic        upd_taken_i = 1'b0;
  logic [31:0] upd_target_i = '0;
  logic        upd_mispred_i = 1'b0;
  logic        flush_i = 1'b0;
`ifdef BP_PERF_EN
  logic [31:0] perf_lookup_o, perf_update_o, perf_mispred_o;
`endif

  branch_predictor_btb dut (
    .clk(clk), .rst(rst), .lookup_pc_i(lookup_pc_i),
    .pred_hit_o(pred_hit_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .upd_en_i(upd_en_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_target_i(upd_target_i), .upd_mispred_i(upd_mispred_i),
`ifdef BP_PERF_EN
    .perf_lookup_o(perf_lookup_o), .perf_update_o(perf_update_o), .perf_mispred_o(perf_mispred_o),
`endif
    .flush_i(flush_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        hit;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  exp_t q[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  // Reference model: one record per index, counters as plain integers.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  int unsigned m_cnt   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  localparam int unsigned CMAX = (1 << CNT_W) - 1;
  localparam int unsigned HALF = 1 << (CNT_W - 1);

  function automatic int unsigned idx_of(logic [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction
  function automatic int unsigned tag_of(logic [31:0] pc);
    return (pc / (4 * ENTRIES)) % (1 << TAG_W);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < int'(ENTRIES); i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_cnt[i] = HALF - 1; m_tgt[i] = '0;
    end
  endfunction

  function automatic exp_t predict(string name, logic [31:0] pc);
    exp_t e;
    int unsigned i = idx_of(pc);
    e.name   = name;
    e.hit    = m_valid[i] && (m_tag[i] == tag_of(pc));
    e.taken  = e.hit && (m_cnt[i] >= HALF);
    e.target = e.taken ? m_tgt[i] : pc + 32'd4;
    return e;
  endfunction

  function automatic void m_update(bit en, logic [31:0] pc, bit tk, logic [31:0] tgt, bit fl);
    int unsigned i = idx_of(pc);
    bit hit = m_valid[i] && (m_tag[i] == tag_of(pc));
    if (fl) begin
      for (int k = 0; k < int'(ENTRIES); k++) begin m_valid[k] = 0; m_cnt[k] = HALF - 1; end
    end else if (en) begin
      if (hit && tk) begin
        if (m_cnt[i] < CMAX) m_cnt[i]++;
        m_tgt[i] = tgt;
      end else if (hit) begin
        if (m_cnt[i] > 0) m_cnt[i]--;
      end else if (tk) begin
        m_valid[i] = 1; m_tag[i] = tag_of(pc); m_tgt[i] = tgt; m_cnt[i] = HALF;
      end
    end
  endfunction

  // Monitor: compares every presented lookup against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: DUT output with no expectation queued");
      end else begin
        e = q.pop_front();
        if (pred_hit_o !== e.hit || pred_taken_o !== e.taken || pred_target_o !== e.target) begin
          errors++;
          $display("FAIL %s: got hit=%b taken=%b target=%h, expected hit=%b taken=%b target=%h",
                   e.name, pred_hit_o, pred_taken_o, pred_target_o, e.hit, e.taken, e.target);
        end
      end
    end
  end

  task automatic cycle(string name, logic [31:0] lpc, bit en, logic [31:0] upc, bit tk,
                       logic [31:0] tgt, bit mis, bit fl);
    @(negedge clk);
    lookup_pc_i = lpc; upd_en_i = en; upd_pc_i = upc; upd_taken_i = tk;
    upd_target_i = tgt; upd_mispred_i = mis; flush_i = fl;
    #1;
    q.push_back(predict(name, lpc));
    ->sample_ev;
    if (rst) m_update(en, upc, tk, tgt, fl);
  endtask

  task automatic look(string name, logic [31:0] lpc);
    cycle(name, lpc, 0, '0, 0, '0, 0, 0);
  endtask

  task automatic upd(string name, logic [31:0] lpc, logic [31:0] upc, bit tk, logic [31:0] tgt);
    cycle(name, lpc, 1, upc, tk, tgt, 0, 0);
  endtask

  function automatic logic [31:0] rpc();
    if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFFC;
    return $urandom & 32'h0000_0FFC;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    // Outputs while held in reset, including the address-wrap target.
    look("reset_lookup", 32'h100);
    look("reset_wrap", 32'hFFFF_FFFC);
    @(negedge clk); rst = 1'b1;
    look("post_reset", 32'h100);

    upd("alloc_same_cycle", 32'h100, 32'h100, 1, 32'h200);
    look("alloc_visible", 32'h100);
    upd("sat_t1", 32'h100, 32'h100, 1, 32'h200);
    upd("sat_t2", 32'h100, 32'h100, 1, 32'h200);
    for (int k = 0; k < 4; k++) upd($sformatf("sat_nt%0d", k), 32'h100, 32'h100, 0, '0);
    look("sat_floor", 32'h100);
    upd("resat_t", 32'h100, 32'h100, 1, 32'h240);
    look("resat_after", 32'h100);

    upd("conflict_a", 32'h140, 32'h100, 1, 32'h200);
    upd("conflict_b", 32'h100, 32'h140, 1, 32'h400);
    look("conflict_evicted", 32'h100);
    look("conflict_owner", 32'h140);
    upd("nt_miss_no_alloc", 32'h180, 32'h180, 0, 32'h500);
    look("nt_miss_intact", 32'h140);
    look("nt_miss_absent", 32'h180);

    upd("pre_flush_alloc", 32'h304, 32'h208, 1, 32'h600);
    cycle("flush_with_upd", 32'h140, 1, 32'h300, 1, 32'h700, 0, 1);
    look("flush_no_300", 32'h300);
    look("flush_no_140", 32'h140);
    look("flush_no_208", 32'h208);

    upd("async_prep", 32'h100, 32'h100, 1, 32'h200);
    look("async_prep_hit", 32'h100);
    // Asynchronous reset mid-cycle: hit must drop with no clock edge.
    @(negedge clk);
    upd_en_i = 1'b0; flush_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    m_reset();
    q.push_back(predict("async_reset_immediate", 32'h100));
    ->sample_ev;
    @(negedge clk); rst = 1'b1;
    look("async_reset_after", 32'h100);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] upc = rpc();
      logic [31:0] lpc = ($urandom_range(0, 1) == 0) ? upc : rpc();
      cycle("random", lpc, $urandom_range(0, 3) != 0, upc, $urandom_range(0, 2) != 0,
            $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1), $urandom_range(0, 49) == 0);
    end

`ifdef BP_PERF_EN
    @(negedge clk); upd_en_i = 1'b0; flush_i = 1'b0; rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    m_reset();
    for (int k = 0; k < 10; k++) cycle("perf_upd", 32'h100, 1, 32'h100, 1, 32'h200, k < 3, 0);
    @(negedge clk); upd_en_i = 1'b0;
    checks++;
    if (perf_update_o !== 32'd10) begin
      errors++; $display("FAIL perf_update: got %0d expected 10", perf_update_o);
    end
    checks++;
    if (perf_mispred_o !== 32'd3) begin
      errors++; $display("FAIL perf_mispred: got %0d expected 3", perf_mispred_o);
    end
`endif

    @(negedge clk);
    upd_en_i = 1'b0; flush_i = 1'b0;
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
